sca_blk_alloc: RTL and testbench
================================

Name: sca_blk_alloc

Overview:
- Free-list manager and arbiter for the 16 SCA storage blocks.
- Hands out a free 4-bit block address to the LCT write path on request, and takes blocks back from the readout path when digitization/readout of a block completes.
- Keeps a busy mask, a free count and error flags for status/monitor.
- Sits between the SCA write controller (allocation side) and the readout controller (release side).

Parameters:
TMR, 0, when 1 the FSM state, free count, head and tail pointers are triplicated and majority-voted each cycle; no functional change.

Ports:
CLK  in  1  system clock (25 MHz domain); all logic rising-edge.
RST_B  in  1  asynchronous reset, active low.
ALLOC  in  1  allocation request from the write path; one request per high cycle.
RELEASE  in  1  release request from the readout path; one block per high cycle.
REL_ADR  in  4  block address being released; qualified by RELEASE.
CLR_ERR  in  1  clears the error state and triggers re-initialisation of the pool.
READY  out  1  high only in RUN state.
GRANT  out  1  one-cycle pulse: ALLOC accepted, ALLOC_ADR is new.
ALLOC_ADR  out  4  most recently granted block address; holds between grants.
SCAFULL  out  1  one-cycle pulse: ALLOC refused because no block is free (overwrite case).
NFREE  out  5  number of free blocks, 0..16.
BUSY_MASK  out  16  bit i = 1 while block i is allocated.
ERR_DBLREL  out  1  sticky: release of a block that was not allocated.

Behaviour:
- Storage: 16x4 circular free list; 4-bit head (pop) and tail (push) pointers; 5-bit free count.
- Reset (RST_B low, asynchronous):
  - state = INIT, init counter = 0, head = tail = 0, NFREE = 0, BUSY_MASK = 0.
  - ALLOC_ADR = 0; GRANT, SCAFULL, ERR_DBLREL, READY = 0.
- FSM states INIT, RUN, ERROR:
  - INIT: each cycle writes free_list[cnt] = cnt, cnt++.
  - INIT: after 16 cycles (cnt wraps 15->0), go to RUN with NFREE = 16, head = 0, tail = 0, BUSY_MASK = 0.
  - INIT: ALLOC and RELEASE are ignored; GRANT and SCAFULL stay 0.
  - RUN: the normal allocate/release operation described below.
  - RUN -> ERROR: on a double release.
  - ERROR: READY = 0; ALLOC and RELEASE are ignored; outputs hold except the GRANT and SCAFULL pulses, which are 0.
  - ERROR -> INIT: on CLR_ERR. The INIT entry clears ERR_DBLREL, BUSY_MASK and NFREE, and resets the pointers.
  - CLR_ERR in RUN or INIT has no effect.
- Allocate (RUN, ALLOC sampled at edge n):
  - NFREE > 0: at n+1, GRANT = 1, ALLOC_ADR = free_list[head], head++ (mod 16), NFREE--, BUSY_MASK[adr] = 1.
  - NFREE == 0: at n+1, SCAFULL = 1, GRANT = 0, ALLOC_ADR unchanged. The write path reuses (overwrites) that block. No pointer or count change.
- Release (RUN, RELEASE sampled at edge n):
  - BUSY_MASK[REL_ADR] == 1: at n+1, free_list[tail] = REL_ADR, tail++, NFREE++, BUSY_MASK[REL_ADR] = 0.
  - BUSY_MASK[REL_ADR] == 0: nothing is pushed; ERR_DBLREL = 1 and state = ERROR at n+1.
- Simultaneous ALLOC and RELEASE in the same cycle:
  - Allocation is evaluated on the pre-cycle NFREE.
  - Both operations take effect; NFREE is unchanged on a successful pair.
  - NFREE == 0 with both: SCAFULL pulses (no bypass grant); the released block is pushed, so NFREE = 1 at n+1.
  - Releasing the block being granted in the same cycle cannot occur, because the grant is not yet visible; if REL_ADR is free, this is the double-release rule.
  - When a double release coincides with a valid alloc, the alloc still completes at n+1, then the FSM enters ERROR.
- Invariant: NFREE + popcount(BUSY_MASK) == 16 in RUN. Pointer wrap is mod 16; NFREE never exceeds 16 or drops below 0.
- GRANT and SCAFULL are registered single-cycle pulses; back-to-back ALLOC gives back-to-back GRANTs.

Test Plan:
- Reset release, idle 16 cycles -> READY rises at cycle 17; NFREE = 16, BUSY_MASK = 0x0000.
- 3 consecutive ALLOC -> GRANT each cycle, ALLOC_ADR = 0,1,2; NFREE = 13; BUSY_MASK = 0x0007.
- 16 ALLOCs, then a 17th -> 17th gives SCAFULL = 1, GRANT = 0, ALLOC_ADR stays 15. Then RELEASE REL_ADR = 5 followed by ALLOC -> ALLOC_ADR = 5, NFREE returns to 0.
- At NFREE = 0, ALLOC + RELEASE(3) in the same cycle -> SCAFULL pulse; NFREE = 1; BUSY_MASK bit 3 cleared.
- After 2 allocs, RELEASE REL_ADR = 9 (free) -> ERR_DBLREL = 1, READY = 0; further ALLOC ignored. Then CLR_ERR -> 16-cycle INIT, READY = 1, NFREE = 16, next grant = 0.
- Assert RST_B low mid-INIT and again mid-RUN with ALLOC active -> all outputs cleared immediately, with no GRANT on the cycle RST_B rises.

Source files
------------

// File: rtl/sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// sca_blk_alloc
//
// Free-list manager and arbiter for the 16 SCA storage blocks. The LCT write
// path asks for a block with ALLOC and receives a 4-bit block address. The
// readout path hands that block back with RELEASE/REL_ADR once digitisation
// and readout of the block have completed. A busy mask, a free count and a
// sticky double-release flag are kept for status and monitoring.
//
// Ports
//   CLK         system clock (25 MHz). All logic runs on the rising edge.
//   RST_B       asynchronous reset, active low.
//   ALLOC       allocation request. One request per high cycle.
//   RELEASE     release request. One block per high cycle.
//   REL_ADR     block being released. Qualified by RELEASE.
//   CLR_ERR     leaves ERROR and re-initialises the pool.
//   READY       high only in RUN.
//   GRANT       one-cycle pulse: ALLOC accepted, ALLOC_ADR is new.
//   ALLOC_ADR   most recently granted block. Holds between grants.
//   SCAFULL     one-cycle pulse: ALLOC refused because the pool is empty.
//               The write path then overwrites its current block.
//   NFREE       number of free blocks, 0..16.
//   BUSY_MASK   bit i set while block i is allocated.
//   ERR_DBLREL  sticky: a block that was not allocated was released.
//
// Parameter
//   TMR         1 = triplicate and majority-vote the FSM state, the free
//               count and the head/tail pointers every cycle.
// ---------------------------------------------------------------------------
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_INIT  | write free_list[cnt] = cnt for 16 cycles. Requests are ignored.
//   ST_RUN   | normal allocate/release service. READY is high.
//   ST_ERROR | double release seen. Requests are ignored until CLR_ERR.
//
module sca_blk_alloc #(
    parameter bit TMR = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic        ALLOC,
    input  logic        RELEASE,
    input  logic [3:0]  REL_ADR,
    input  logic        CLR_ERR,
    output logic        READY,
    output logic        GRANT,
    output logic [3:0]  ALLOC_ADR,
    output logic        SCAFULL,
    output logic [4:0]  NFREE,
    output logic [15:0] BUSY_MASK,
    output logic        ERR_DBLREL
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // Control word: {state, nfree, head, tail}. The all-zero word is the
    // reset condition (INIT, empty pool, pointers at 0). This lets the
    // protected and unprotected register variants share one reset value.
    localparam int CW = 15;

    state_t        state_v;
    state_t        state_d;
    logic [4:0]    nfree_v;
    logic [4:0]    nfree_d;
    logic [3:0]    head_v;
    logic [3:0]    head_d;
    logic [3:0]    tail_v;
    logic [3:0]    tail_d;
    logic [CW-1:0] ctl_d;
    logic [CW-1:0] ctl_v;

    logic [3:0]    free_list [16];
    logic [3:0]    init_cnt;
    logic [3:0]    pop_adr;
    logic [15:0]   busy_mask;
    logic [3:0]    alloc_adr;
    logic          grant;
    logic          scafull;
    logic          err_dblrel;

    logic          init_wr;
    logic          pop;
    logic          push;
    logic          full;
    logic          dbl;
    logic          clr_pool;

    assign ctl_d   = {state_d, nfree_d, head_d, tail_d};
    assign state_v = state_t'(ctl_v[14:13]);
    assign nfree_v = ctl_v[12:8];
    assign head_v  = ctl_v[7:4];
    assign tail_v  = ctl_v[3:0];

    generate
        if (TMR) begin : g_tmr
            logic [CW-1:0] ctl_q [3];

            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    ctl_q[0] <= '0;
                    ctl_q[1] <= '0;
                    ctl_q[2] <= '0;
                end else begin
                    ctl_q[0] <= ctl_d;
                    ctl_q[1] <= ctl_d;
                    ctl_q[2] <= ctl_d;
                end
            end

            // Bitwise 2-of-3 vote. All copies reload from the voted next
            // value, so a single upset is scrubbed within one cycle.
            assign ctl_v = (ctl_q[0] & ctl_q[1]) |
                           (ctl_q[0] & ctl_q[2]) |
                           (ctl_q[1] & ctl_q[2]);
        end else begin : g_simplex
            logic [CW-1:0] ctl_q;

            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    ctl_q <= '0;
                end else begin
                    ctl_q <= ctl_d;
                end
            end

            assign ctl_v = ctl_q;
        end
    endgenerate

    assign pop_adr = free_list[head_v];

    // Next-state and per-cycle operation decode.
    always_comb begin
        state_d  = state_v;
        nfree_d  = nfree_v;
        head_d   = head_v;
        tail_d   = tail_v;
        init_wr  = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        full     = 1'b0;
        dbl      = 1'b0;
        clr_pool = 1'b0;

        unique case (state_v)
            ST_INIT: begin
                init_wr = 1'b1;
                if (init_cnt == 4'd15) begin
                    state_d = ST_RUN;
                    nfree_d = 5'd16;
                    head_d  = 4'd0;
                    tail_d  = 4'd0;
                end
            end

            ST_RUN: begin
                // Both decisions use the pre-cycle count and mask. A block
                // granted this cycle is still free in busy_mask, so an
                // attempt to release it in the same cycle is a double release.
                if (ALLOC) begin
                    if (nfree_v != 5'd0) begin
                        pop = 1'b1;
                    end else begin
                        full = 1'b1;
                    end
                end
                if (RELEASE) begin
                    if (busy_mask[REL_ADR]) begin
                        push = 1'b1;
                    end else begin
                        dbl = 1'b1;
                    end
                end
                if (pop) begin
                    head_d = head_v + 4'd1;
                end
                if (push) begin
                    tail_d = tail_v + 4'd1;
                end
                nfree_d = nfree_v + 5'(push) - 5'(pop);
                if (dbl) begin
                    state_d = ST_ERROR;
                end
            end

            ST_ERROR: begin
                if (CLR_ERR) begin
                    state_d  = ST_INIT;
                    clr_pool = 1'b1;
                    nfree_d  = 5'd0;
                    head_d   = 4'd0;
                    tail_d   = 4'd0;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // The free list is plain storage. INIT rewrites every entry, so it
    // needs no reset.
    always_ff @(posedge CLK) begin
        if (init_wr) begin
            free_list[init_cnt] <= init_cnt;
        end else if (push) begin
            free_list[tail_v] <= REL_ADR;
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            init_cnt   <= 4'd0;
            busy_mask  <= '0;
            alloc_adr  <= 4'd0;
            grant      <= 1'b0;
            scafull    <= 1'b0;
            err_dblrel <= 1'b0;
        end else begin
            grant   <= pop;
            scafull <= full;

            if (init_wr) begin
                init_cnt <= init_cnt + 4'd1;
            end else if (clr_pool) begin
                init_cnt <= 4'd0;
            end

            if (pop) begin
                alloc_adr <= pop_adr;
            end

            if (clr_pool || init_wr) begin
                busy_mask <= '0;
            end else begin
                // The popped block is free and the pushed block is busy, so
                // these two writes never target the same bit.
                if (pop) begin
                    busy_mask[pop_adr] <= 1'b1;
                end
                if (push) begin
                    busy_mask[REL_ADR] <= 1'b0;
                end
            end

            if (clr_pool) begin
                err_dblrel <= 1'b0;
            end else if (dbl) begin
                err_dblrel <= 1'b1;
            end
        end
    end

    assign READY      = (state_v == ST_RUN);
    assign GRANT      = grant;
    assign ALLOC_ADR  = alloc_adr;
    assign SCAFULL    = scafull;
    assign NFREE      = nfree_v;
    assign BUSY_MASK  = busy_mask;
    assign ERR_DBLREL = err_dblrel;

endmodule

// File: tb/tb_sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// tb_sca_blk_alloc
//
// Bench for the SCA block allocator. It runs a queue-based reference model
// alongside the DUT every cycle. On top of that it applies a table of
// directed vectors, hand-written sequences for the error, reset and
// re-initialisation cases, and long randomized traffic.
// ---------------------------------------------------------------------------
module tb_sca_blk_alloc;

    logic        CLK     = 1'b0;
    logic        RST_B   = 1'b0;
    logic        ALLOC   = 1'b0;
    logic        RELEASE = 1'b0;
    logic [3:0]  REL_ADR = 4'd0;
    logic        CLR_ERR = 1'b0;
    logic        READY;
    logic        GRANT;
    logic [3:0]  ALLOC_ADR;
    logic        SCAFULL;
    logic [4:0]  NFREE;
    logic [15:0] BUSY_MASK;
    logic        ERR_DBLREL;

    sca_blk_alloc #(.TMR(1'b0)) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .ALLOC      (ALLOC),
        .RELEASE    (RELEASE),
        .REL_ADR    (REL_ADR),
        .CLR_ERR    (CLR_ERR),
        .READY      (READY),
        .GRANT      (GRANT),
        .ALLOC_ADR  (ALLOC_ADR),
        .SCAFULL    (SCAFULL),
        .NFREE      (NFREE),
        .BUSY_MASK  (BUSY_MASK),
        .ERR_DBLREL (ERR_DBLREL)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 = init, 1 = run, 2 = error.
    int          m_mode;
    int          m_icnt;
    logic [3:0]  m_fifo[$];
    logic [15:0] m_busy;
    logic [3:0]  m_adr;
    bit          m_grant;
    bit          m_full;
    bit          m_err;

    typedef struct {
        bit          a;
        bit          r;
        logic [3:0]  ra;
        bit          g;
        logic [3:0]  ea;
        bit          f;
        logic [4:0]  nf;
        logic [15:0] bm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkvec(bit a, bit r, logic [3:0] ra, bit g,
                                   logic [3:0] ea, bit f, logic [4:0] nf,
                                   logic [15:0] bm);
        vec_t v;
        v.a = a; v.r = r; v.ra = ra; v.g = g;
        v.ea = ea; v.f = f; v.nf = nf; v.bm = bm;
        return v;
    endfunction

    function automatic logic [31:0] dut_word();
        return 32'({READY, GRANT, ALLOC_ADR, SCAFULL, NFREE, BUSY_MASK, ERR_DBLREL});
    endfunction

    function automatic logic [31:0] m_word();
        logic [4:0] nf;
        nf = 5'(m_fifo.size());
        return 32'({m_mode == 1, m_grant, m_adr, m_full, nf, m_busy, m_err});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_mode  = 0;
        m_icnt  = 0;
        m_fifo.delete();
        m_busy  = '0;
        m_adr   = 4'd0;
        m_grant = 1'b0;
        m_full  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held before it.
    task automatic m_step();
        bit dbl;
        m_grant = 1'b0;
        m_full  = 1'b0;
        case (m_mode)
            0: begin
                m_icnt++;
                if (m_icnt == 16) begin
                    m_mode = 1;
                    m_icnt = 0;
                    for (int i = 0; i < 16; i++) m_fifo.push_back(4'(i));
                end
            end
            1: begin
                dbl = RELEASE && !m_busy[REL_ADR];
                if (ALLOC) begin
                    if (m_fifo.size() > 0) begin
                        m_adr = m_fifo.pop_front();
                        m_busy[m_adr] = 1'b1;
                        m_grant = 1'b1;
                    end else begin
                        m_full = 1'b1;
                    end
                end
                if (RELEASE && !dbl) begin
                    m_busy[REL_ADR] = 1'b0;
                    m_fifo.push_back(REL_ADR);
                end
                if (dbl) begin
                    m_err  = 1'b1;
                    m_mode = 2;
                end
            end
            default: begin
                if (CLR_ERR) begin
                    m_mode = 0;
                    m_icnt = 0;
                    m_fifo.delete();
                    m_busy = '0;
                    m_err  = 1'b0;
                end
            end
        endcase
    endtask

    task automatic set_in(input bit a, input bit r, input logic [3:0] ra, input bit c);
        ALLOC   = a;
        RELEASE = r;
        REL_ADR = ra;
        CLR_ERR = c;
    endtask

    task automatic tick();
        @(posedge CLK);
        m_step();
        #1;
        chk("cycle_model", dut_word(), m_word());
    endtask

    // Called 1 ns after a rising edge. Reset pulses low between edges, and
    // the outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        RST_B = 1'b0;
        m_reset();
        #1;
        chk("async_reset_clear", dut_word(), 32'h0);
        #1;
        RST_B = 1'b1;
    endtask

    // From INIT: 16 idle edges. READY must stay low for 15 edges and be
    // high after the 16th.
    task automatic boot_idle(input string tag);
        set_in(0, 0, 4'd0, 0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk({tag, "_ready_low"}, 32'(READY), 32'd0);
        end
        chk({tag, "_ready_high"}, 32'(READY), 32'd1);
        chk({tag, "_nfree16"}, 32'(NFREE), 32'd16);
        chk({tag, "_busy0"}, 32'(BUSY_MASK), 32'h0);
    endtask

    initial begin
        logic [31:0] bm32;
        int          pct;
        int          busy_list[$];

        // Power-on reset.
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("poweron_reset", dut_word(), 32'h0);
        #4;
        RST_B = 1'b1;
        boot_idle("boot");

        // Directed vector table.
        for (int k = 0; k < 3; k++) begin
            bm32 = (32'd1 << (k + 1)) - 32'd1;
            vecs.push_back(mkvec(1, 0, 4'd0, 1, 4'(k), 0, 5'(15 - k), bm32[15:0]));
        end
        vecs.push_back(mkvec(0, 0, 4'd0, 0, 4'd2, 0, 5'd13, 16'h0007));
        for (int k = 3; k < 16; k++) begin
            bm32 = (32'd1 << (k + 1)) - 32'd1;
            vecs.push_back(mkvec(1, 0, 4'd0, 1, 4'(k), 0, 5'(15 - k), bm32[15:0]));
        end
        vecs.push_back(mkvec(1, 0, 4'd0, 0, 4'd15, 1, 5'd0, 16'hFFFF));
        vecs.push_back(mkvec(0, 1, 4'd5, 0, 4'd15, 0, 5'd1, 16'hFFDF));
        vecs.push_back(mkvec(1, 0, 4'd0, 1, 4'd5,  0, 5'd0, 16'hFFFF));
        vecs.push_back(mkvec(1, 1, 4'd3, 0, 4'd5,  1, 5'd1, 16'hFFF7));
        vecs.push_back(mkvec(0, 0, 4'd0, 0, 4'd5,  0, 5'd1, 16'hFFF7));
        vecs.push_back(mkvec(1, 0, 4'd0, 1, 4'd3,  0, 5'd0, 16'hFFFF));

        foreach (vecs[i]) begin
            set_in(vecs[i].a, vecs[i].r, vecs[i].ra, 0);
            tick();
            chk($sformatf("vec%0d", i),
                32'({GRANT, ALLOC_ADR, SCAFULL, NFREE, BUSY_MASK}),
                32'({vecs[i].g, vecs[i].ea, vecs[i].f, vecs[i].nf, vecs[i].bm}));
        end

        // Reset mid-RUN with ALLOC held: there must be no grant until INIT ends.
        set_in(1, 0, 4'd0, 0);
        tick();
        async_reset();
        tick();
        chk("no_grant_after_reset", 32'(GRANT), 32'd0);
        for (int i = 2; i <= 16; i++) tick();
        chk("ready_after_reset_run", 32'(READY), 32'd1);
        tick();
        chk("first_grant_after_reset", 32'({GRANT, ALLOC_ADR}), 32'({1'b1, 4'd0}));
        tick();
        chk("second_grant", 32'({GRANT, ALLOC_ADR}), 32'({1'b1, 4'd1}));

        // CLR_ERR while in RUN has no effect.
        set_in(0, 0, 4'd0, 1);
        tick();
        chk("clr_in_run", 32'({READY, NFREE, BUSY_MASK}), 32'({1'b1, 5'd14, 16'h0003}));

        // Double release of free block 9 after two allocs.
        set_in(0, 1, 4'd9, 0);
        tick();
        chk("dblrel_flag", 32'({ERR_DBLREL, READY, NFREE, BUSY_MASK}),
            32'({1'b1, 1'b0, 5'd14, 16'h0003}));
        set_in(1, 1, 4'd0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("error_ignores_alloc", 32'({GRANT, SCAFULL, NFREE, BUSY_MASK}),
                32'({1'b0, 1'b0, 5'd14, 16'h0003}));
        end
        set_in(0, 0, 4'd0, 1);
        tick();
        chk("clr_err_enters_init", 32'({ERR_DBLREL, READY, NFREE, BUSY_MASK}), 32'h0);
        boot_idle("reinit");
        set_in(1, 0, 4'd0, 0);
        tick();
        chk("grant_after_reinit", 32'({GRANT, ALLOC_ADR}), 32'({1'b1, 4'd0}));

        // A double release that coincides with a valid alloc: the grant
        // still completes.
        set_in(1, 1, 4'd7, 0);
        tick();
        chk("dbl_with_alloc", 32'({GRANT, ALLOC_ADR, ERR_DBLREL, READY, NFREE}),
            32'({1'b1, 4'd1, 1'b1, 1'b0, 5'd14}));
        set_in(0, 0, 4'd0, 1);
        tick();

        // Reset mid-INIT.
        set_in(0, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) tick();
        async_reset();
        boot_idle("midinit");

        // Randomized traffic against the model.
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 60 : 90);
            for (int c = 0; c < 500; c++) begin
                busy_list.delete();
                for (int b = 0; b < 16; b++) if (m_busy[b]) busy_list.push_back(b);
                ALLOC   = ($urandom_range(99) < pct);
                RELEASE = ($urandom_range(99) < 50);
                CLR_ERR = ($urandom_range(99) < 25);
                if (busy_list.size() > 0 && $urandom_range(39) != 0)
                    REL_ADR = 4'(busy_list[$urandom_range(busy_list.size() - 1)]);
                else
                    REL_ADR = 4'($urandom_range(15));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
